// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcodes, forward-select
// encoding and the registered control bundle.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRLV = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_BGT  = 4'b1001;
  localparam logic [3:0] ALU_BGE  = 4'b1010;
  localparam logic [3:0] ALU_BEQ  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_BNE  = 4'b1110;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic alu_src;
    logic reg_dst;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational forwarding select for the two EX source operands.
module forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output fwd_sel_e          fwd_a_o,
  output fwd_sel_e          fwd_b_o
);

  // The younger EX/MEM result wins over MEM/WB; $0 is never forwarded.
  function automatic fwd_sel_e pick(input logic [REG_AW-1:0] src,
                                    input logic              em_we,
                                    input logic [REG_AW-1:0] em_rd,
                                    input logic              mw_we,
                                    input logic [REG_AW-1:0] mw_rd);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (em_we && (em_rd != '0) && (em_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_o = pick(ex_rs_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i);
    fwd_b_o = pick(ex_rt_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall
// detection and bubble insertion on stall or branch flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [4:0]        id_shamt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [3:0]        id_alu_ctrl_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              id_branch_i,
  input  logic              flush_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              hazard_stall_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [4:0]        alu_shamt_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] ex_wdata_o,
  output logic [REG_AW-1:0] ex_dest_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_branch_o
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;

  logic [REG_AW-1:0] ex_dest;
  logic              hazard_stall;
  fwd_sel_e          fwd_a, fwd_b;
  logic [DATA_W-1:0] fwd_a_val, fwd_b_val;

  assign ex_dest = ctrl_q.reg_dst ? rd_q : rt_q;

  // rt is compared even for I-type consumers; a spurious stall is harmless.
  assign hazard_stall = id_valid_i & ~flush_i & ctrl_q.valid & ctrl_q.mem_read &
                        (ex_dest != '0) &
                        ((ex_dest == id_rs_i) | (ex_dest == id_rt_i));

  always_comb begin
    ctrl_d     = '0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm_d      = '0;
    shamt_d    = '0;
    rs_d       = '0;
    rt_d       = '0;
    rd_d       = '0;
    alu_ctrl_d = '0;
    if (!(flush_i || hazard_stall)) begin
      ctrl_d.valid      = id_valid_i;
      ctrl_d.alu_src    = id_alu_src_i;
      ctrl_d.reg_dst    = id_reg_dst_i;
      ctrl_d.reg_write  = id_reg_write_i;
      ctrl_d.mem_read   = id_mem_read_i;
      ctrl_d.mem_write  = id_mem_write_i;
      ctrl_d.mem_to_reg = id_mem_to_reg_i;
      ctrl_d.branch     = id_branch_i;
      rs_data_d         = id_rs_data_i;
      rt_data_d         = id_rt_data_i;
      imm_d             = id_imm_i;
      shamt_d           = id_shamt_i;
      rs_d              = id_rs_i;
      rt_d              = id_rt_i;
      rd_d              = id_rd_i;
      alu_ctrl_d        = id_alu_ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      shamt_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      alu_ctrl_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      shamt_q    <= shamt_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  forward_unit #(
    .REG_AW(REG_AW)
  ) u_forward_unit (
    .ex_rs_i          (rs_q),
    .ex_rt_i          (rt_q),
    .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_rd_i       (exmem_rd_i),
    .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i       (memwb_rd_i),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b)
  );

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: fwd_a_val = exmem_result_i;
      FWD_MEMWB: fwd_a_val = memwb_data_i;
      default:   fwd_a_val = rs_data_q;
    endcase
    case (fwd_b)
      FWD_EXMEM: fwd_b_val = exmem_result_i;
      FWD_MEMWB: fwd_b_val = memwb_data_i;
      default:   fwd_b_val = rt_data_q;
    endcase
  end

  assign hazard_stall_o  = hazard_stall;
  assign alu_src1_o      = fwd_a_val;
  assign alu_src2_o      = ctrl_q.alu_src ? imm_q : fwd_b_val;
  assign alu_shamt_o     = shamt_q;
  assign alu_ctrl_o      = alu_ctrl_q;
  assign ex_wdata_o      = fwd_b_val;
  assign ex_dest_o       = ex_dest;
  assign ex_valid_o      = ctrl_q.valid;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign ex_branch_o     = ctrl_q.branch;

endmodule
